// File: rtl/vpe_bias_act_pipe.sv
// Two-stage bias-add / round-shift / saturate / ReLU pipeline for VPE lanes.
// Stage 1 registers the biased sum per lane; stage 2 post-processes it into the output register.

module vpe_bap_lane #(
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 3,
  parameter int SYM_SAT = 1
) (
  input  logic [DATA_W:0]    sum,
  input  logic [DATA_W-1:0]  raw,
  input  logic [1:0]         mode,
  input  logic [SHIFT_W-1:0] shift,
  output logic [DATA_W-1:0]  res,
  output logic               clamp
);
  localparam int RW   = DATA_W + 2;
  localparam int MAXI = 2**(DATA_W-1) - 1;
  localparam int MINI = (SYM_SAT != 0) ? -MAXI : -MAXI - 1;
  localparam logic signed [RW-1:0] MAX_V = RW'(MAXI);
  localparam logic signed [RW-1:0] MIN_V = RW'(MINI);

  logic signed [RW-1:0] ext, rnd, r, sat;

  always_comb begin
    ext   = {sum[DATA_W], sum[DATA_W], sum};
    rnd   = RW'(1) << (shift - 1'b1);
    r     = (shift == '0) ? ext : ((ext + rnd) >>> shift);
    sat   = r;
    clamp = 1'b0;
    if (r > MAX_V) begin
      sat   = MAX_V;
      clamp = 1'b1;
    end else if (r < MIN_V) begin
      sat   = MIN_V;
      clamp = 1'b1;
    end
    res = sat[DATA_W-1:0];
    // ReLU zeroing happens after the clamp decision, so it never counts as a clamp
    if (mode[1] && sat[RW-1]) res = '0;
    if (mode == 2'b00) begin
      res   = raw;
      clamp = 1'b0;
    end
  end
endmodule

module vpe_bias_act_pipe #(
  parameter  int LANES      = 8,
  parameter  int DATA_W     = 8,
  parameter  int BIAS_DEPTH = 4,
  parameter  int SHIFT_W    = 3,
  parameter  int SYM_SAT    = 1,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = $clog2(BIAS_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATA_W-1:0] i_data,
  input  logic                    i_data_v,
  output logic                    o_data_rdy,
  input  logic [1:0]              i_mode,
  input  logic [SHIFT_W-1:0]      i_shift,
  input  logic [SEL_W-1:0]        i_bias_sel,
  input  logic [4:0]              i_rf_idx,
  input  logic [1:0]              i_rf_mux,
  input  logic                    i_bias_we,
  input  logic [SEL_W-1:0]        i_bias_addr,
  input  logic [LANES*DATA_W-1:0] i_bias_wdata,
  output logic [LANES*DATA_W-1:0] o_data,
  output logic                    o_data_v,
  input  logic                    i_out_rdy,
  output logic [4:0]              o_rf_idx,
  output logic [1:0]              o_rf_mux,
  output logic                    o_en_relu,
  output logic [CNT_W-1:0]        o_sat_cnt,
  input  logic                    i_sat_clr
);
  logic [2:1] vld_pipe_q, vld_pipe_d;
  logic [LANES-1:0][DATA_W:0]   s1_sum_q, s1_sum_d;
  logic [LANES-1:0][DATA_W-1:0] s1_raw_q, s1_raw_d;
  logic [1:0]         s1_mode_q, s1_mode_d;
  logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
  logic [4:0]         s1_idx_q, s1_idx_d;
  logic [1:0]         s1_mux_q, s1_mux_d;
  logic [LANES-1:0][DATA_W-1:0] out_data_q, out_data_d;
  logic [4:0]         out_idx_q, out_idx_d;
  logic [1:0]         out_mux_q, out_mux_d;
  logic               out_relu_q, out_relu_d;
  logic [CNT_W-1:0]   sat_cnt_q, sat_cnt_d;
  logic [BIAS_DEPTH-1:0][LANES-1:0][DATA_W-1:0] bias_q, bias_d;

  logic [LANES-1:0][DATA_W-1:0] in_lane, bias_lane, lane_res;
  logic [LANES-1:0]             lane_clamp;
  logic [CNT_W:0]               pop, cnt_sum;
  logic                         s1_load, s2_load;

  assign in_lane   = i_data;
  assign bias_lane = bias_q[i_bias_sel];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vpe_bap_lane #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .SYM_SAT(SYM_SAT)) u_lane (
      .sum   (s1_sum_q[g]),
      .raw   (s1_raw_q[g]),
      .mode  (s1_mode_q),
      .shift (s1_shift_q),
      .res   (lane_res[g]),
      .clamp (lane_clamp[g])
    );
  end

  assign s2_load    = vld_pipe_q[1] & (~vld_pipe_q[2] | i_out_rdy);
  assign o_data_rdy = ~vld_pipe_q[1] | s2_load;
  assign s1_load    = i_data_v & o_data_rdy;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_sum_d   = s1_sum_q;
    s1_raw_d   = s1_raw_q;
    s1_mode_d  = s1_mode_q;
    s1_shift_d = s1_shift_q;
    s1_idx_d   = s1_idx_q;
    s1_mux_d   = s1_mux_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_mux_d  = out_mux_q;
    out_relu_d = out_relu_q;
    sat_cnt_d  = sat_cnt_q;
    bias_d     = bias_q;
    pop        = '0;
    cnt_sum    = '0;

    vld_pipe_d[1] = s1_load | (vld_pipe_q[1] & ~s2_load);
    vld_pipe_d[2] = s2_load | (vld_pipe_q[2] & ~i_out_rdy);

    // Bias is read from the pre-write bank, so a same-cycle write is seen by later beats only
    if (s1_load) begin
      for (int i = 0; i < LANES; i++)
        s1_sum_d[i] = {in_lane[i][DATA_W-1], in_lane[i]} + {bias_lane[i][DATA_W-1], bias_lane[i]};
      s1_raw_d   = in_lane;
      s1_mode_d  = i_mode;
      s1_shift_d = i_shift;
      s1_idx_d   = i_rf_idx;
      s1_mux_d   = i_rf_mux;
    end

    for (int i = 0; i < LANES; i++) pop = pop + (CNT_W+1)'(lane_clamp[i]);

    if (s2_load) begin
      out_data_d = lane_res;
      out_idx_d  = s1_idx_q;
      out_mux_d  = s1_mux_q;
      out_relu_d = s1_mode_q[1];
      cnt_sum    = {1'b0, sat_cnt_q} + pop;
      sat_cnt_d  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
    if (i_sat_clr) sat_cnt_d = '0;

    if (i_bias_we) bias_d[i_bias_addr] = i_bias_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_sum_q   <= '0;
      s1_raw_q   <= '0;
      s1_mode_q  <= '0;
      s1_shift_q <= '0;
      s1_idx_q   <= '0;
      s1_mux_q   <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_mux_q  <= '0;
      out_relu_q <= 1'b0;
      sat_cnt_q  <= '0;
      bias_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_sum_q   <= s1_sum_d;
      s1_raw_q   <= s1_raw_d;
      s1_mode_q  <= s1_mode_d;
      s1_shift_q <= s1_shift_d;
      s1_idx_q   <= s1_idx_d;
      s1_mux_q   <= s1_mux_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_mux_q  <= out_mux_d;
      out_relu_q <= out_relu_d;
      sat_cnt_q  <= sat_cnt_d;
      bias_q     <= bias_d;
    end
  end

  assign o_data    = out_data_q;
  assign o_data_v  = vld_pipe_q[2];
  assign o_rf_idx  = out_idx_q;
  assign o_rf_mux  = out_mux_q;
  assign o_en_relu = out_relu_q;
  assign o_sat_cnt = sat_cnt_q;
endmodule

// File: tb/tb_vpe_bias_act_pipe.sv
// Bench for vpe_bias_act_pipe: directed vector table, hand sequences, and a
// randomized stream checked against an arithmetic lane model and an in-order scoreboard.

module tb_vpe_bias_act_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_data, i_bias_wdata, o_data;
  logic        i_data_v, o_data_rdy, i_bias_we, o_data_v, i_out_rdy, o_en_relu, i_sat_clr;
  logic [1:0]  i_mode, i_bias_sel, i_bias_addr, i_rf_mux, o_rf_mux;
  logic [2:0]  i_shift;
  logic [4:0]  i_rf_idx, o_rf_idx;
  logic [15:0] o_sat_cnt;

  vpe_bias_act_pipe dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_data_v(i_data_v), .o_data_rdy(o_data_rdy),
    .i_mode(i_mode), .i_shift(i_shift), .i_bias_sel(i_bias_sel), .i_rf_idx(i_rf_idx),
    .i_rf_mux(i_rf_mux), .i_bias_we(i_bias_we), .i_bias_addr(i_bias_addr),
    .i_bias_wdata(i_bias_wdata), .o_data(o_data), .o_data_v(o_data_v), .i_out_rdy(i_out_rdy),
    .o_rf_idx(o_rf_idx), .o_rf_mux(o_rf_mux), .o_en_relu(o_en_relu), .o_sat_cnt(o_sat_cnt),
    .i_sat_clr(i_sat_clr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [63:0] mbias [4];
  int          mcnt;

  typedef struct {
    logic [7:0]  bias;
    logic [1:0]  sel, mode;
    logic [2:0]  shift;
    logic [63:0] data, exp;
    logic [4:0]  idx;
    logic [1:0]  mux;
    bit          relu;
    int          inc;
  } vec_t;
  vec_t tbl[8];

  logic [63:0] q_data[$];
  logic [6:0]  q_side[$];
  bit          q_relu[$];
  int          inflight, accepted;
  bit          held_v;
  logic [63:0] held_d;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Lane model straight from the arithmetic rules: add, round-half-up shift, clamp, ReLU.
  task automatic model(input logic [63:0] d, input logic [63:0] b, input logic [1:0] mode,
                       input int sh, output logic [63:0] res, output int clamps);
    int a, bb, s, r;
    clamps = 0;
    res = d;
    if (mode != 2'b00) begin
      for (int i = 0; i < 8; i++) begin
        a  = $signed(d[i*8 +: 8]);
        bb = $signed(b[i*8 +: 8]);
        s  = a + bb;
        r  = (sh == 0) ? s : ((s + (1 << (sh - 1))) >>> sh);
        if (r > 127)       begin r = 127;  clamps++; end
        else if (r < -127) begin r = -127; clamps++; end
        if (mode[1] && r < 0) r = 0;
        res[i*8 +: 8] = 8'(r);
      end
    end
  endtask

  task automatic wr_bias(input logic [1:0] a, input logic [7:0] b);
    i_bias_we = 1'b1; i_bias_addr = a; i_bias_wdata = {8{b}};
    step();
    i_bias_we = 1'b0;
    mbias[a] = {8{b}};
  endtask

  task automatic rnd_cycle(input bit vin, input bit ordy);
    logic [63:0] d, bd, e;
    logic [1:0]  mode, sel, wa;
    logic [2:0]  sh;
    logic [4:0]  idx;
    logic [1:0]  mux;
    bit          we;
    int          cl;
    d = {$urandom, $urandom};
    mode = 2'($urandom_range(0, 3)); sh = 3'($urandom_range(0, 7));
    sel = 2'($urandom_range(0, 3));  idx = 5'($urandom_range(0, 31)); mux = 2'($urandom_range(0, 3));
    we = ($urandom_range(0, 3) == 0); wa = 2'($urandom_range(0, 3)); bd = {$urandom, $urandom};
    i_data = d; i_mode = mode; i_shift = sh; i_bias_sel = sel; i_rf_idx = idx; i_rf_mux = mux;
    i_data_v = vin; i_out_rdy = ordy;
    i_bias_we = we; i_bias_addr = wa; i_bias_wdata = bd;
    #1;
    chk("rdy", {63'd0, o_data_rdy}, {63'd0, (inflight < 2) || ordy});
    if (held_v) begin
      chk("hold_v", {63'd0, o_data_v}, 64'd1);
      chk("hold_data", o_data, held_d);
    end
    if (o_data_v) begin
      if (q_data.size() == 0) chk("spurious_v", {63'd0, o_data_v}, 64'd0);
      else if (ordy) begin
        chk("stream_data", o_data, q_data.pop_front());
        chk("stream_side", {57'd0, o_rf_idx, o_rf_mux}, {57'd0, q_side.pop_front()});
        chk("stream_relu", {63'd0, o_en_relu}, {63'd0, q_relu.pop_front()});
        inflight--;
      end
    end
    held_v = o_data_v && !ordy;
    held_d = o_data;
    if (vin && o_data_rdy) begin
      model(d, mbias[sel], mode, int'(sh), e, cl);
      q_data.push_back(e); q_side.push_back({idx, mux}); q_relu.push_back(mode[1]);
      mcnt += cl; inflight++; accepted++;
    end
    if (we) mbias[wa] = bd;
    @(posedge clk); #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] e;
    int          cl, cnt_exp, cyc;
    bit          saw_v;
    tbl[0] = '{8'h05, 2'd0, 2'd1, 3'd0, 64'h0000000000807E10, 64'h0505050505857F15, 5'd1,  2'd1, 1'b0, 1};
    tbl[1] = '{8'hFF, 2'd1, 2'd2, 3'd0, 64'h0000000000000381, 64'h0000000000000200, 5'd2,  2'd3, 1'b1, 1};
    tbl[2] = '{8'h00, 2'd2, 2'd1, 3'd2, 64'h000000000000FA06, 64'h000000000000FF02, 5'd3,  2'd0, 1'b0, 0};
    tbl[3] = '{8'h05, 2'd3, 2'd0, 3'd0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 5'd17, 2'd2, 1'b0, 0};
    tbl[4] = '{8'h7F, 2'd0, 2'd3, 3'd0, 64'h000000000000807F, 64'h7F7F7F7F7F7F007F, 5'd4,  2'd1, 1'b1, 1};
    tbl[5] = '{8'h7F, 2'd1, 2'd1, 3'd7, 64'h000000000000807F, 64'h0101010101010002, 5'd5,  2'd2, 1'b0, 0};
    tbl[6] = '{8'h80, 2'd2, 2'd1, 3'd0, 64'h0000000000007F80, 64'h818181818181FF81, 5'd6,  2'd3, 1'b0, 7};
    tbl[7] = '{8'h00, 2'd3, 2'd1, 3'd1, 64'h000000000003FDFF, 64'h000000000002FF00, 5'd7,  2'd0, 1'b0, 0};

    rst = 1'b1; i_data = '0; i_data_v = 1'b0; i_mode = '0; i_shift = '0; i_bias_sel = '0;
    i_rf_idx = '0; i_rf_mux = '0; i_bias_we = 1'b0; i_bias_addr = '0; i_bias_wdata = '0;
    i_out_rdy = 1'b1; i_sat_clr = 1'b0;
    for (int i = 0; i < 4; i++) mbias[i] = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_v", {63'd0, o_data_v}, 64'd0);
    chk("rst_data", o_data, 64'd0);
    chk("rst_side", {56'd0, o_rf_idx, o_rf_mux, o_en_relu}, 64'd0);
    chk("rst_cnt", {48'd0, o_sat_cnt}, 64'd0);
    chk("rst_rdy", {63'd0, o_data_rdy}, 64'd1);

    cnt_exp = 0;
    for (int k = 0; k < 8; k++) begin
      wr_bias(tbl[k].sel, tbl[k].bias);
      i_data = tbl[k].data; i_mode = tbl[k].mode; i_shift = tbl[k].shift;
      i_bias_sel = tbl[k].sel; i_rf_idx = tbl[k].idx; i_rf_mux = tbl[k].mux; i_data_v = 1'b1;
      step();
      i_data_v = 1'b0;
      step();
      cnt_exp += tbl[k].inc;
      chk($sformatf("vec%0d_v", k), {63'd0, o_data_v}, 64'd1);
      chk($sformatf("vec%0d_data", k), o_data, tbl[k].exp);
      chk($sformatf("vec%0d_side", k), {57'd0, o_rf_idx, o_rf_mux}, {57'd0, tbl[k].idx, tbl[k].mux});
      chk($sformatf("vec%0d_relu", k), {63'd0, o_en_relu}, {63'd0, tbl[k].relu});
      chk($sformatf("vec%0d_cnt", k), {48'd0, o_sat_cnt}, 64'(cnt_exp));
    end
    step();

    // clear coinciding with an 8-lane clamp increment: clear wins
    wr_bias(2'd2, 8'h7F);
    i_data = {8{8'h7F}}; i_mode = 2'd1; i_shift = '0; i_bias_sel = 2'd2; i_data_v = 1'b1;
    step();
    i_data_v = 1'b0; i_sat_clr = 1'b1;
    step();
    i_sat_clr = 1'b0;
    chk("clr_win_cnt", {48'd0, o_sat_cnt}, 64'd0);
    chk("clr_win_data", o_data, {8{8'h7F}});
    i_data_v = 1'b1;
    step();
    i_data_v = 1'b0;
    step();
    chk("cnt_after_clr", {48'd0, o_sat_cnt}, 64'd8);
    i_sat_clr = 1'b1;
    step();
    i_sat_clr = 1'b0;
    chk("clr_alone", {48'd0, o_sat_cnt}, 64'd0);

    // bias write and beat on the same entry in the same cycle: beat sees the old value
    wr_bias(2'd1, 8'h00);
    i_data = {8{8'h01}}; i_mode = 2'd1; i_shift = '0; i_bias_sel = 2'd1; i_data_v = 1'b1;
    i_bias_we = 1'b1; i_bias_addr = 2'd1; i_bias_wdata = {8{8'h10}};
    step();
    i_bias_we = 1'b0; mbias[1] = {8{8'h10}};
    step();
    i_data_v = 1'b0;
    chk("bias_old", o_data, {8{8'h01}});
    step();
    chk("bias_new", o_data, {8{8'h11}});
    step();
    i_sat_clr = 1'b1;
    step();
    i_sat_clr = 1'b0;

    // 10 back-to-back beats with out_rdy 1,0,0,1,... then random traffic, then drain
    mcnt = 0; inflight = 0; accepted = 0; held_v = 1'b0; cyc = 0;
    while (accepted < 10 && cyc < 100) begin
      rnd_cycle(1'b1, (cyc % 4 == 0) || (cyc % 4 == 3));
      cyc++;
    end
    chk("ten_accepted", 64'(accepted), 64'd10);
    for (int c = 0; c < 400; c++) rnd_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    for (int c = 0; c < 6; c++) rnd_cycle(1'b0, 1'b1);
    i_bias_we = 1'b0;
    chk("drain_empty", 64'(q_data.size()), 64'd0);
    chk("rand_cnt", {48'd0, o_sat_cnt}, 64'(mcnt));

    // counter sticks at all-ones after 8200 fully clamped beats
    wr_bias(2'd0, 8'h80);
    model({8{8'h80}}, mbias[0], 2'd1, 0, e, cl);
    i_data = {8{8'h80}}; i_mode = 2'd1; i_shift = '0; i_bias_sel = 2'd0; i_out_rdy = 1'b1;
    i_data_v = 1'b1;
    for (int c = 0; c < 8200; c++) step();
    i_data_v = 1'b0;
    step(); step(); step();
    chk("sticky_lanes", 64'(cl), 64'd8);
    chk("sticky_cnt", {48'd0, o_sat_cnt}, 64'hFFFF);
    chk("sticky_data", o_data, e);

    // reset with two beats in flight drops them
    i_out_rdy = 1'b0; i_data_v = 1'b1;
    step(); step();
    i_data_v = 1'b0;
    chk("pre_rst_v", {63'd0, o_data_v}, 64'd1);
    chk("pre_rst_rdy", {63'd0, o_data_rdy}, 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0; i_out_rdy = 1'b1;
    saw_v = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (o_data_v) saw_v = 1'b1;
      step();
    end
    chk("post_rst_no_v", {63'd0, saw_v}, 64'd0);
    chk("post_rst_data", o_data, 64'd0);
    chk("post_rst_cnt", {48'd0, o_sat_cnt}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vpe_bias_act_pipe.md
Name: vpe_bias_act_pipe

Overview:
- Parametrised successor of the VPE bias adder.
- Adds a per-lane bias to a LANES-wide signed activation vector, then applies an optional rounding right-shift, saturation and ReLU.
- Uses a 2-stage valid/ready pipeline with full backpressure. Biases come from an internal bias bank with BIAS_DEPTH entries, selected per beat.
- Sits between the VPE accumulator output and the register-file writeback; rf_idx/rf_mux sideband travels with the data.

Parameters:
- LANES, 8, number of lanes per beat.
- DATA_W, 8, signed two's-complement width per lane.
- BIAS_DEPTH, 4, bias bank entries (power of 2, >=2).
- SHIFT_W, 3, width of the shift amount field.
- SYM_SAT, 1: 1 = negative clamp at -(2^(DATA_W-1)-1); 0 = clamp at -2^(DATA_W-1).
- CNT_W, 16, saturation event counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_data  in  LANES*DATA_W  activation; lane i = bits [i*DATA_W +: DATA_W].
- i_data_v  in  1  input valid.
- o_data_rdy  out  1  input ready.
- i_mode  in  2  00 bypass, 01 bias+sat, 10 bias+sat+ReLU, 11 = same as 10.
- i_shift  in  SHIFT_W  arithmetic right-shift amount.
- i_bias_sel  in  log2(BIAS_DEPTH)  bias bank entry for this beat.
- i_rf_idx  in  5  sideband, passed through.
- i_rf_mux  in  2  sideband, passed through.
- i_bias_we  in  1  bias bank write enable.
- i_bias_addr  in  log2(BIAS_DEPTH)  write address.
- i_bias_wdata  in  LANES*DATA_W  bias vector; same lane packing as i_data.
- o_data  out  LANES*DATA_W  result; lane 0 at LSB, no lane reversal.
- o_data_v  out  1  output valid.
- i_out_rdy  in  1  downstream ready.
- o_rf_idx  out  5  sideband aligned with o_data.
- o_rf_mux  out  2  sideband aligned with o_data.
- o_en_relu  out  1  1 when the beat's mode had ReLU enabled.
- o_sat_cnt  out  CNT_W  lanes clamped since last clear.
- i_sat_clr  in  1  clears o_sat_cnt.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - Both stage valids cleared; o_data_v=0.
  - o_data, o_rf_idx, o_rf_mux, o_en_relu = 0; o_sat_cnt = 0.
  - All bias bank entries = 0.
  - Reset mid-stream drops in-flight beats with no output.
- Handshake:
  - A beat transfers on i_data_v & o_data_rdy; output transfers on o_data_v & i_out_rdy.
  - Stage k loads when it is empty or stage k+1 (or downstream) takes its beat this cycle.
  - o_data_rdy = ~s1_v | s2_load (combinational).
  - Full throughput of 1 beat/cycle when i_out_rdy=1. Latency is 2 cycles from accept to o_data_v.
  - Stalled outputs hold stable. No beat is lost or duplicated.
- Stage 1 registers, per lane:
  - sum = sext(a) + sext(bias[i_bias_sel]), DATA_W+1 bits.
  - Also registers mode, shift, raw data and sideband.
- Stage 2 (output register):
  - Bypass: out = raw input lane, unchanged; no shift, no saturation, no count.
  - Otherwise, when shift>0: r = (sum + 2^(shift-1)) >>> shift, arithmetic, computed in DATA_W+2 bits (round half up). When shift=0: r = sum.
  - Saturate r to [MIN, 2^(DATA_W-1)-1], where MIN is set by SYM_SAT.
  - ReLU modes: a negative saturated value becomes 0.
  - A lane counts as clamped if saturation altered it; a ReLU zeroing alone does not count.
- Bias bank:
  - Write is registered and visible to beats accepted from the next cycle.
  - A beat accepted in the same cycle as a write to its entry uses the old bias.
- o_sat_cnt:
  - Adds the number of clamped lanes when stage 2 loads a beat.
  - Sticks at 2^CNT_W-1.
  - When i_sat_clr and an increment coincide, clear wins (result 0).
- o_en_relu = 1 for mode 10 or 11; zeroed in bypass. Sideband fields are copied unchanged.

Test Plan:
- Reset, bias[0]=all 0x05, mode=01, shift=0, lane0=0x10, lane1=0x7E, lane2=0x80 -> after 2 cycles lane0=0x15, lane1=0x7F (clamp), lane2=0x85; o_sat_cnt=1.
- SYM_SAT=1, bias=0xFF, mode=10, lane0=0x81, lane1=0x03 -> lane0=0x00 (clamp to 0x81, then ReLU), lane1=0x02; o_en_relu=1; o_sat_cnt+=1.
- mode=01, shift=2, bias=0, lane0=0x06 (6), lane1=0xFA (-6) -> lane0=0x02, lane1=0xFF (-1; round half up).
- Stream 10 back-to-back beats with i_out_rdy toggling 1,0,0,1,...: output sequence matches the input order exactly, o_data holds while stalled, o_data_rdy=0 when both stages are full and i_out_rdy=0.
- Same cycle: bias write addr 1 = 0x10, with a beat accepted using sel=1 (old bias 0x00) -> beat uses 0x00; the next beat uses 0x10.
- mode=00, i_data=0x0123456789ABCDEF, rf_idx=5'd17, rf_mux=2'd2 -> o_data identical, o_rf_idx=17, o_rf_mux=2, o_sat_cnt unchanged; rst asserted with 2 beats in flight -> no o_data_v afterwards.
